control_unit: RTL and testbench

- Instruction decoder and program counter for the 8-bit UAZ8 microcontroller.
- Decodes a 9-bit instruction into register-file, ALU, bus and memory controls.
- Keeps the 8-bit instruction address, with conditional jumps to a register value.
- Sits between the instruction memory and the datapath (register file, ALU, data memory).

---
 rtl/control_unit.sv | 131 +++++++++++++
 tb/tb_control_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// UAZ8 control unit: combinational instruction decode plus the 8-bit program counter
// with conditional register-indirect jumps.
module control_unit (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [8:0] i_Instruction,
    input  logic [7:0] i_Rx,
    input  logic [2:0] Flags,
    output logic [2:0] Sel_OP,
    output logic [5:0] SelR,
    output logic       RW,
    output logic [1:0] Sel_Op_OutBus,
    output logic [2:0] Sel_DW,
    output logic [7:0] o_Addres_Instr_Bus
);

    localparam logic [2:0] OP_LOAD_IMM  = 3'b000;
    localparam logic [2:0] OP_LOAD_MEM  = 3'b001;
    localparam logic [2:0] OP_STORE_IMM = 3'b010;
    localparam logic [2:0] OP_STORE_REG = 3'b011;
    localparam logic [2:0] OP_MOVE      = 3'b100;
    localparam logic [2:0] OP_MATH      = 3'b101;
    localparam logic [2:0] OP_JUMP      = 3'b110;

    localparam logic [1:0] BUS_RY   = 2'b00;
    localparam logic [1:0] BUS_IMM  = 2'b01;
    localparam logic [1:0] BUS_ALU  = 2'b10;
    localparam logic [1:0] BUS_IDLE = 2'b11;

    localparam logic [2:0] DW_NONE    = 3'b000;
    localparam logic [2:0] DW_REG_IMM = 3'b001;
    localparam logic [2:0] DW_REG_MEM = 3'b010;
    localparam logic [2:0] DW_REG_REG = 3'b011;
    localparam logic [2:0] DW_REG_ALU = 3'b100;
    localparam logic [2:0] DW_MEM_BUS = 3'b101;

    logic [2:0] opcode;
    logic [2:0] field_a;
    logic [2:0] field_b;
    logic       jump_taken;
    logic [7:0] pc_q;
    logic [7:0] pc_d;

    assign opcode  = i_Instruction[8:6];
    assign field_a = i_Instruction[5:3];
    assign field_b = i_Instruction[2:0];

    always_comb begin
        Sel_OP        = 3'b000;
        SelR          = 6'b000000;
        RW            = 1'b0;
        Sel_Op_OutBus = BUS_IDLE;
        Sel_DW        = DW_NONE;
        case (opcode)
            OP_LOAD_IMM: begin
                SelR          = {field_a, 3'b000};
                Sel_Op_OutBus = BUS_IMM;
                Sel_DW        = DW_REG_IMM;
            end
            OP_LOAD_MEM: begin
                SelR          = {field_a, field_b};
                Sel_Op_OutBus = BUS_RY;
                Sel_DW        = DW_REG_MEM;
            end
            OP_STORE_IMM: begin
                SelR          = {field_a, 3'b000};
                RW            = 1'b1;
                Sel_Op_OutBus = BUS_IMM;
                Sel_DW        = DW_MEM_BUS;
            end
            OP_STORE_REG: begin
                SelR          = {field_a, field_b};
                RW            = 1'b1;
                Sel_Op_OutBus = BUS_RY;
                Sel_DW        = DW_MEM_BUS;
            end
            OP_MOVE: begin
                SelR          = {field_a, field_b};
                Sel_Op_OutBus = BUS_RY;
                Sel_DW        = DW_REG_REG;
            end
            OP_MATH: begin
                SelR          = {field_a, 3'b000};
                Sel_OP        = field_b;
                Sel_Op_OutBus = BUS_ALU;
                Sel_DW        = DW_REG_ALU;
            end
            OP_JUMP: begin
                SelR = {field_a, 3'b000};
            end
            default: ;
        endcase
        // Reset squashes the datapath controls so nothing is written while the core restarts.
        if (Rst) begin
            Sel_OP        = 3'b000;
            SelR          = 6'b000000;
            RW            = 1'b0;
            Sel_Op_OutBus = BUS_IDLE;
            Sel_DW        = DW_NONE;
        end
    end

    always_comb begin
        jump_taken = 1'b0;
        if (opcode == OP_JUMP) begin
            case (field_b)
                3'b000:  jump_taken = 1'b1;
                3'b001:  jump_taken = Flags[0];
                3'b010:  jump_taken = Flags[1];
                3'b011:  jump_taken = Flags[2];
                3'b100:  jump_taken = ~Flags[0];
                3'b101:  jump_taken = ~Flags[1];
                3'b110:  jump_taken = ~Flags[2];
                default: jump_taken = 1'b0;
            endcase
        end
    end

    assign pc_d = jump_taken ? i_Rx : pc_q + 8'd1;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pc_q <= 8'h00;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_Addres_Instr_Bus = pc_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed decode/jump/wrap cases, then randomized instructions
// checked against an opcode-table and flag-rule model with an integer PC.
module tb_control_unit;

    logic       Clk;
    logic       Rst;
    logic [8:0] i_Instruction;
    logic [7:0] i_Rx;
    logic [2:0] Flags;
    logic [2:0] Sel_OP;
    logic [5:0] SelR;
    logic       RW;
    logic [1:0] Sel_Op_OutBus;
    logic [2:0] Sel_DW;
    logic [7:0] o_Addres_Instr_Bus;

    int vectors;
    int miscompares;
    int pc_model;

    // Per-opcode table: bus source, write destination, write enable, Ry field used.
    logic [1:0] bus_tab   [8];
    logic [2:0] dw_tab    [8];
    logic       rw_tab    [8];
    logic       ry_tab    [8];

    control_unit dut (
        .Clk                (Clk),
        .Rst                (Rst),
        .i_Instruction      (i_Instruction),
        .i_Rx               (i_Rx),
        .Flags              (Flags),
        .Sel_OP             (Sel_OP),
        .SelR               (SelR),
        .RW                 (RW),
        .Sel_Op_OutBus      (Sel_Op_OutBus),
        .Sel_DW             (Sel_DW),
        .o_Addres_Instr_Bus (o_Addres_Instr_Bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Decoded fields packed as {Sel_OP, SelR, RW, OutBus, DW}.
    function automatic logic [14:0] model_decode(input logic [8:0] instr, input logic rst);
        logic [2:0] op;
        logic [2:0] a;
        logic [2:0] b;
        logic [2:0] alu;
        logic [5:0] sr;
        op = instr[8:6];
        a  = instr[5:3];
        b  = instr[2:0];
        if (rst || op == 3'd7) return {3'b000, 6'b000000, 1'b0, 2'b11, 3'b000};
        alu = (op == 3'd5) ? b : 3'b000;
        sr  = {a, ry_tab[op] ? b : 3'b000};
        return {alu, sr, rw_tab[op], bus_tab[op], dw_tab[op]};
    endfunction

    function automatic bit model_taken(input logic [8:0] instr, input logic [2:0] fl);
        int c;
        bit f;
        if (instr[8:6] != 3'd6) return 1'b0;
        c = int'(instr[2:0]);
        if (c == 0) return 1'b1;
        if (c == 7) return 1'b0;
        f = fl[(c - 1) % 3];
        return (c >= 4) ? !f : f;
    endfunction

    function automatic logic [14:0] dut_decode();
        return {Sel_OP, SelR, RW, Sel_Op_OutBus, Sel_DW};
    endfunction

    task automatic apply(input logic [8:0] instr, input logic [7:0] rx, input logic [2:0] fl);
        @(negedge Clk);
        i_Instruction = instr;
        i_Rx          = rx;
        Flags         = fl;
        #1;
    endtask

    task automatic edge_and_settle();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst           = 1'b1;
        i_Instruction = 9'b011_101_010;
        i_Rx          = 8'h55;
        Flags         = 3'b111;
        #3;
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_pc: got %h expected 00", o_Addres_Instr_Bus);
        end
        vectors++;
        if (dut_decode() !== {3'b000, 6'b000000, 1'b0, 2'b11, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_decode: got %b expected %b", dut_decode(),
                     {3'b000, 6'b000000, 1'b0, 2'b11, 3'b000});
        end
        @(posedge Clk);
        #1;
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold_pc: got %h expected 00", o_Addres_Instr_Bus);
        end
        @(negedge Clk);
        Rst           = 1'b0;
        i_Instruction = 9'b111_100_001;
        for (int i = 0; i < 3; i++) edge_and_settle();
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h03) begin
            miscompares++;
            $display("FAIL reset_release_count: got %h expected 03", o_Addres_Instr_Bus);
        end
        pc_model = 3;
        $display("test_reset: pc=%h", o_Addres_Instr_Bus);
    endtask

    task automatic test_decode();
        logic [8:0]  instr_tab [6];
        logic [14:0] exp_tab   [6];
        instr_tab[0] = 9'b000_001_100; exp_tab[0] = {3'b000, 6'b001000, 1'b0, 2'b01, 3'b001};
        instr_tab[1] = 9'b001_010_001; exp_tab[1] = {3'b000, 6'b010001, 1'b0, 2'b00, 3'b010};
        instr_tab[2] = 9'b010_011_010; exp_tab[2] = {3'b000, 6'b011000, 1'b1, 2'b01, 3'b101};
        instr_tab[3] = 9'b011_111_110; exp_tab[3] = {3'b000, 6'b111110, 1'b1, 2'b00, 3'b101};
        instr_tab[4] = 9'b100_001_010; exp_tab[4] = {3'b000, 6'b001010, 1'b0, 2'b00, 3'b011};
        instr_tab[5] = 9'b101_011_001; exp_tab[5] = {3'b001, 6'b011000, 1'b0, 2'b10, 3'b100};
        for (int i = 0; i < 6; i++) begin
            apply(instr_tab[i], 8'h00, 3'b000);
            vectors++;
            if (dut_decode() !== exp_tab[i]) begin
                miscompares++;
                $display("FAIL decode_%0d: instr %b got %b expected %b", i, instr_tab[i],
                         dut_decode(), exp_tab[i]);
            end
            edge_and_settle();
            pc_model = (pc_model + 1) % 256;
            vectors++;
            if (o_Addres_Instr_Bus !== 8'(pc_model)) begin
                miscompares++;
                $display("FAIL decode_pc_%0d: got %h expected %h", i, o_Addres_Instr_Bus,
                         8'(pc_model));
            end
            $display("test_decode: instr=%b ctl=%b pc=%h", instr_tab[i], dut_decode(),
                     o_Addres_Instr_Bus);
        end
    endtask

    task automatic test_jump();
        apply(9'b110_100_001, 8'h40, 3'b001);
        vectors++;
        if (dut_decode() !== {3'b000, 6'b100000, 1'b0, 2'b11, 3'b000}) begin
            miscompares++;
            $display("FAIL jump_decode: got %b expected %b", dut_decode(),
                     {3'b000, 6'b100000, 1'b0, 2'b11, 3'b000});
        end
        edge_and_settle();
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h40) begin
            miscompares++;
            $display("FAIL jump_taken_zero: got %h expected 40", o_Addres_Instr_Bus);
        end
        apply(9'b110_100_001, 8'h40, 3'b000);
        edge_and_settle();
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h41) begin
            miscompares++;
            $display("FAIL jump_not_taken: got %h expected 41", o_Addres_Instr_Bus);
        end
        apply(9'b110_100_000, 8'h10, 3'b000);
        edge_and_settle();
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h10) begin
            miscompares++;
            $display("FAIL jump_always: got %h expected 10", o_Addres_Instr_Bus);
        end
        apply(9'b110_100_111, 8'h80, 3'b111);
        edge_and_settle();
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h11) begin
            miscompares++;
            $display("FAIL jump_never: got %h expected 11", o_Addres_Instr_Bus);
        end
        pc_model = 'h11;
        $display("test_jump: pc=%h", o_Addres_Instr_Bus);
    endtask

    task automatic test_wrap();
        apply(9'b110_010_000, 8'hFF, 3'b000);
        edge_and_settle();
        apply(9'b111_100_001, 8'h00, 3'b000);
        edge_and_settle();
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap_ff_to_00: got %h expected 00", o_Addres_Instr_Bus);
        end
        edge_and_settle();
        #2;
        Rst = 1'b1;
        #1;
        vectors++;
        if (o_Addres_Instr_Bus !== 8'h00) begin
            miscompares++;
            $display("FAIL async_reset_pc: got %h expected 00", o_Addres_Instr_Bus);
        end
        Rst = 1'b0;
        pc_model = 0;
        $display("test_wrap: pc=%h", o_Addres_Instr_Bus);
    endtask

    task automatic test_random();
        logic [8:0]  instr;
        logic [7:0]  rx;
        logic [2:0]  fl;
        logic [14:0] exp_ctl;
        for (int n = 0; n < 300; n++) begin
            instr = 9'($urandom);
            // Bias toward jumps so every condition/flag combination gets exercised.
            if ($urandom_range(0, 2) == 0) instr[8:6] = 3'b110;
            rx = 8'($urandom);
            fl = 3'($urandom);
            apply(instr, rx, fl);
            exp_ctl = model_decode(instr, 1'b0);
            vectors++;
            if (dut_decode() !== exp_ctl) begin
                miscompares++;
                $display("FAIL rand_decode_%0d: instr %b got %b expected %b", n, instr,
                         dut_decode(), exp_ctl);
            end
            edge_and_settle();
            pc_model = model_taken(instr, fl) ? int'(rx) : (pc_model + 1) % 256;
            vectors++;
            if (o_Addres_Instr_Bus !== 8'(pc_model)) begin
                miscompares++;
                $display("FAIL rand_pc_%0d: instr %b rx %h flags %b got %h expected %h", n,
                         instr, rx, fl, o_Addres_Instr_Bus, 8'(pc_model));
            end
            if ($urandom_range(0, 24) == 0) begin
                #1;
                Rst = 1'b1;
                #1;
                vectors++;
                if ({o_Addres_Instr_Bus, dut_decode()} !== {8'h00, model_decode(instr, 1'b1)}) begin
                    miscompares++;
                    $display("FAIL rand_reset_%0d: got pc %h ctl %b expected pc 00 ctl %b", n,
                             o_Addres_Instr_Bus, dut_decode(), model_decode(instr, 1'b1));
                end
                Rst = 1'b0;
                pc_model = 0;
            end
            $display("test_random %0d: instr=%b rx=%h fl=%b pc=%h", n, instr, rx, fl,
                     o_Addres_Instr_Bus);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        pc_model    = 0;
        bus_tab[0] = 2'b01; dw_tab[0] = 3'b001; rw_tab[0] = 1'b0; ry_tab[0] = 1'b0;
        bus_tab[1] = 2'b00; dw_tab[1] = 3'b010; rw_tab[1] = 1'b0; ry_tab[1] = 1'b1;
        bus_tab[2] = 2'b01; dw_tab[2] = 3'b101; rw_tab[2] = 1'b1; ry_tab[2] = 1'b0;
        bus_tab[3] = 2'b00; dw_tab[3] = 3'b101; rw_tab[3] = 1'b1; ry_tab[3] = 1'b1;
        bus_tab[4] = 2'b00; dw_tab[4] = 3'b011; rw_tab[4] = 1'b0; ry_tab[4] = 1'b1;
        bus_tab[5] = 2'b10; dw_tab[5] = 3'b100; rw_tab[5] = 1'b0; ry_tab[5] = 1'b0;
        bus_tab[6] = 2'b11; dw_tab[6] = 3'b000; rw_tab[6] = 1'b0; ry_tab[6] = 1'b0;
        bus_tab[7] = 2'b11; dw_tab[7] = 3'b000; rw_tab[7] = 1'b0; ry_tab[7] = 1'b0;
        test_reset();
        test_decode();
        test_jump();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
